// File: rtl/mm_wb_buffer.sv
// rtl/mm_wb_buffer.sv - MXU result de-skew buffer with row-wise RAM write-back
module mm_wb_buffer #(
  parameter int ROWS = 16,
  parameter int COLS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 lsu_mm_wb_ctrl_vld,
  input  logic [3:0]           lsu_mm_wb_ctrl_row_len,
  input  logic [3:0]           lsu_mm_wb_ctrl_col_len,
  input  logic [11:0]          lsu_mm_wb_ctrl_start_addr,
  input  logic [COLS-1:0]      mxu_lsu_wb_vld,
  input  logic [8*COLS-1:0]    mxu_lsu_wb_data,
  output logic                 lsu_mm_wb_ram_write_vld,
  input  logic                 lsu_mm_wb_ram_write_rdy,
  output logic [7:0]           lsu_mm_wb_ram_write_addr,
  output logic [8*COLS-1:0]    lsu_mm_wb_ram_write_data,
  output logic [COLS-1:0]      lsu_mm_wb_ram_write_be,
  output logic                 lsu_mm_wb_busy,
  output logic                 lsu_mm_wb_done
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                ctrl_vld_q;
  logic [RW:0]         row_len_q, row_len_d, row_len_in;
  logic [CW:0]         col_len_q, col_len_d, col_len_in;
  logic [7:0]          base_q, base_d;
  logic [RW-1:0]       cnt_q [COLS];
  logic [RW-1:0]       cnt_d [COLS];
  logic [COLS-1:0]     cnt_done_q, cnt_done_d;
  logic [ROWS-1:0]     pending_q, pending_d, pend_set, pend_clr;
  logic [8*COLS-1:0]   entry_q [ROWS];
  logic [8*COLS-1:0]   entry_d [ROWS];

  logic                wr_vld_q, wr_vld_d;
  logic [RW-1:0]       wr_row_q, wr_row_d;
  logic [7:0]          wr_addr_q, wr_addr_d;
  logic [8*COLS-1:0]   wr_data_q, wr_data_d;
  logic [COLS-1:0]     wr_be_q, wr_be_d;
  logic                busy_q, busy_d;

  logic                start;
  logic                accept;
  logic                last_accept;
  logic                sel_any;
  logic [RW-1:0]       sel_row;
  logic [COLS-1:0]     be_mask;
  logic [8*COLS-1:0]   byte_mask;
  logic                unused_addr_lo;

  // The low address nibble is always zero for line-aligned commands.
  assign unused_addr_lo = ^lsu_mm_wb_ctrl_start_addr[3:0];

  // Decode the command lengths (0 means full size) and detect the start edge.
  always_comb begin
    row_len_in = (lsu_mm_wb_ctrl_row_len == '0) ? (RW+1)'(ROWS)
                                                 : {1'b0, lsu_mm_wb_ctrl_row_len[RW-1:0]};
    col_len_in = (lsu_mm_wb_ctrl_col_len == '0) ? (CW+1)'(COLS)
                                                 : {1'b0, lsu_mm_wb_ctrl_col_len[CW-1:0]};
    start      = (state_q == ST_IDLE) && lsu_mm_wb_ctrl_vld && !ctrl_vld_q;
  end

  // Write handshake and end-of-operation detection.
  always_comb begin
    accept   = wr_vld_q && lsu_mm_wb_ram_write_rdy;
    pend_clr = '0;
    if (accept) begin
      pend_clr[wr_row_q] = 1'b1;
    end
    last_accept = accept && (state_q == ST_DRAIN) && ((pending_q & ~pend_clr) == '0);
  end

  // Control FSM next state plus per-column de-skew capture into the row entries.
  always_comb begin
    state_d    = state_q;
    row_len_d  = row_len_q;
    col_len_d  = col_len_q;
    base_d     = base_q;
    cnt_d      = cnt_q;
    cnt_done_d = cnt_done_q;
    entry_d    = entry_q;
    pend_set   = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_COLLECT;
          row_len_d = row_len_in;
          col_len_d = col_len_in;
          base_d    = lsu_mm_wb_ctrl_start_addr[11:4];
          for (int c = 0; c < COLS; c++) begin
            cnt_d[c] = '0;
            // Unused columns start finished so their valids are ignored.
            cnt_done_d[c] = (c >= int'(col_len_in));
          end
        end
      end
      ST_COLLECT: begin
        for (int c = 0; c < COLS; c++) begin
          if (mxu_lsu_wb_vld[c] && !cnt_done_q[c]) begin
            entry_d[cnt_q[c]][8*c +: 8] = mxu_lsu_wb_data[8*c +: 8];
            cnt_d[c] = cnt_q[c] + RW'(1);
            if (({1'b0, cnt_q[c]} + (RW+1)'(1)) == row_len_q) begin
              cnt_done_d[c] = 1'b1;
            end
            // The last valid column trails the skew, so its capture completes the row.
            if (c == int'(col_len_q) - 1) begin
              pend_set[cnt_q[c]] = 1'b1;
            end
          end
        end
        if (&cnt_done_d) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (last_accept) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    pending_d = (pending_q & ~pend_clr) | pend_set;
    busy_d    = (state_d != ST_IDLE);
  end

  // Pick the lowest pending row and build the masks for the valid columns.
  always_comb begin
    sel_any = |pending_d;
    sel_row = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (pending_d[r]) begin
        sel_row = RW'(r);
      end
    end
    for (int c = 0; c < COLS; c++) begin
      be_mask[c]            = (c < int'(col_len_d));
      byte_mask[8*c +: 8]   = {8{be_mask[c]}};
    end
  end

  // Registered write port: hold while stalled, otherwise present the next pending row
  // using the just-captured entry contents so a row is offered the cycle after completion.
  always_comb begin
    wr_vld_d  = wr_vld_q;
    wr_row_d  = wr_row_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_be_d   = wr_be_q;
    if (!(wr_vld_q && !lsu_mm_wb_ram_write_rdy)) begin
      wr_vld_d = sel_any;
      if (sel_any) begin
        wr_row_d  = sel_row;
        wr_addr_d = base_d + 8'(sel_row);
        wr_data_d = entry_d[sel_row] & byte_mask;
        wr_be_d   = be_mask;
      end else begin
        wr_row_d  = '0;
        wr_addr_d = '0;
        wr_data_d = '0;
        wr_be_d   = '0;
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q    <= ST_IDLE;
      ctrl_vld_q <= 1'b0;
      row_len_q  <= '0;
      col_len_q  <= '0;
      base_q     <= '0;
      cnt_done_q <= '0;
      pending_q  <= '0;
      wr_vld_q   <= 1'b0;
      wr_row_q   <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_be_q    <= '0;
      busy_q     <= 1'b0;
      for (int c = 0; c < COLS; c++) begin
        cnt_q[c] <= '0;
      end
      for (int r = 0; r < ROWS; r++) begin
        entry_q[r] <= '0;
      end
    end else begin
      state_q    <= state_d;
      ctrl_vld_q <= lsu_mm_wb_ctrl_vld;
      row_len_q  <= row_len_d;
      col_len_q  <= col_len_d;
      base_q     <= base_d;
      cnt_done_q <= cnt_done_d;
      pending_q  <= pending_d;
      wr_vld_q   <= wr_vld_d;
      wr_row_q   <= wr_row_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_be_q    <= wr_be_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      entry_q    <= entry_d;
    end
  end

  assign lsu_mm_wb_ram_write_vld  = wr_vld_q;
  assign lsu_mm_wb_ram_write_addr = wr_addr_q;
  assign lsu_mm_wb_ram_write_data = wr_data_q;
  assign lsu_mm_wb_ram_write_be   = wr_be_q;
  assign lsu_mm_wb_busy           = busy_q;
  // Done coincides with the final handshake; suppressed while reset is asserted.
  assign lsu_mm_wb_done           = last_accept && !rst_n;

endmodule

// File: tb/tb_mm_wb_buffer.sv
// tb/tb_mm_wb_buffer.sv - scoreboard bench for mm_wb_buffer
module tb_mm_wb_buffer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ctrl_vld;
  logic [3:0]   ctrl_row_len;
  logic [3:0]   ctrl_col_len;
  logic [11:0]  ctrl_addr;
  logic [15:0]  mxu_vld;
  logic [127:0] mxu_data;
  logic         wr_vld;
  logic         wr_rdy;
  logic [7:0]   wr_addr;
  logic [127:0] wr_data;
  logic [15:0]  wr_be;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  mm_wb_buffer #(.ROWS(16), .COLS(16)) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .lsu_mm_wb_ctrl_vld        (ctrl_vld),
    .lsu_mm_wb_ctrl_row_len    (ctrl_row_len),
    .lsu_mm_wb_ctrl_col_len    (ctrl_col_len),
    .lsu_mm_wb_ctrl_start_addr (ctrl_addr),
    .mxu_lsu_wb_vld            (mxu_vld),
    .mxu_lsu_wb_data           (mxu_data),
    .lsu_mm_wb_ram_write_vld   (wr_vld),
    .lsu_mm_wb_ram_write_rdy   (wr_rdy),
    .lsu_mm_wb_ram_write_addr  (wr_addr),
    .lsu_mm_wb_ram_write_data  (wr_data),
    .lsu_mm_wb_ram_write_be    (wr_be),
    .lsu_mm_wb_busy            (busy),
    .lsu_mm_wb_done            (done)
  );

  typedef struct {
    logic [7:0]   addr;
    logic [127:0] data;
    logic [15:0]  be;
    logic         last;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  int   done_exp = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] row_bytes(input int r, input int cols);
    logic [127:0] v;
    logic [3:0]   rn;
    logic [3:0]   cn;
    v  = '0;
    rn = 4'(r);
    for (int c = 0; c < cols; c++) begin
      cn = 4'(c);
      v[8*c +: 8] = {rn, cn};
    end
    return v;
  endfunction

  task automatic push_op(input int rows, input int cols, input logic [11:0] addr);
    exp_t e;
    for (int r = 0; r < rows; r++) begin
      e.addr = addr[11:4] + 8'(r);
      e.data = row_bytes(r, cols);
      e.be   = '0;
      for (int c = 0; c < cols; c++) e.be[c] = 1'b1;
      e.last = (r == rows - 1);
      sb_q.push_back(e);
    end
    done_exp++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cmd(input int rows, input int cols, input logic [11:0] addr, input bit hold);
    ctrl_row_len = 4'(rows);
    ctrl_col_len = 4'(cols);
    ctrl_addr    = addr;
    ctrl_vld     = 1'b1;
    tick();
    chk("busy_start", busy, 1);
    // Scramble the command fields; the latched copy must be used.
    ctrl_row_len = 4'h7;
    ctrl_col_len = 4'h9;
    ctrl_addr    = 12'h555;
    if (!hold) ctrl_vld = 1'b0;
  endtask

  task automatic drive_stream(input int srows, input int scols, input int lat_cols, input int stop_k);
    int nk;
    int r;
    nk = srows + scols - 1;
    if (stop_k >= 0) nk = stop_k + 1;
    for (int k = 0; k < nk; k++) begin
      mxu_vld  = '0;
      mxu_data = '0;
      for (int c = 0; c < scols; c++) begin
        r = k - c;
        if (r >= 0 && r < srows) begin
          mxu_vld[c] = 1'b1;
          mxu_data[8*c +: 8] = {4'(r), 4'(c)};
        end
      end
      @(negedge clk);
      if (lat_cols > 0 && k == lat_cols - 1) chk("lat_before_row0", wr_vld, 0);
      if (lat_cols > 0 && k == lat_cols)     chk("lat_row0_vld", wr_vld, 1);
      tick();
    end
    mxu_vld  = '0;
    mxu_data = '0;
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (done_cnt >= done_exp) break;
      @(negedge clk);
      #1;
    end
    chk("done_count", done_cnt, done_exp);
  endtask

  task automatic busy_drop();
    chk("busy_at_done", busy, 1);
    @(negedge clk);
    chk("busy_after_done", busy, 0);
  endtask

  // Scoreboard: every accepted write is compared against the oldest expected row.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      done_cnt++;
      chk("done_with_accept", wr_vld & wr_rdy, 1);
    end
    if (wr_vld && wr_rdy) begin
      chk("sb_nonempty", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("wr_addr", wr_addr, e.addr);
        chk("wr_data", wr_data, e.data);
        chk("wr_be", wr_be, e.be);
        chk("done_on_last", done, e.last);
      end
    end else if (wr_vld && sb_q.size() != 0) begin
      chk("stall_addr", wr_addr, sb_q[0].addr);
      chk("stall_data", wr_data, sb_q[0].data);
    end
  end

  initial begin
    int n;
    int dc;
    rst_n        = 1'b1;
    ctrl_vld     = 1'b0;
    ctrl_row_len = '0;
    ctrl_col_len = '0;
    ctrl_addr    = '0;
    mxu_vld      = '0;
    mxu_data     = '0;
    wr_rdy       = 1'b1;
    repeat (2) tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_wr_vld", wr_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_data", wr_data, 0);
    chk("rst_be", wr_be, 0);
    tick();

    // Directed 4x4 with latency check
    push_op(4, 4, 12'h120);
    start_cmd(4, 4, 12'h120, 1'b0);
    drive_stream(4, 4, 4, -1);
    wait_done(50);
    busy_drop();
    tick();

    // Full 16x16, lengths encoded as 0
    push_op(16, 16, 12'h300);
    start_cmd(16, 16, 12'h300, 1'b0);
    drive_stream(16, 16, -1, -1);
    wait_done(100);
    busy_drop();
    tick();

    // Backpressure 4x4
    wr_rdy = 1'b0;
    push_op(4, 4, 12'h450);
    start_cmd(4, 4, 12'h450, 1'b0);
    drive_stream(4, 4, -1, -1);
    repeat (3) tick();
    wr_rdy = 1'b1;
    n = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      n = i;
      if (done) break;
    end
    chk("b2b_cycles", n, 4);
    #1;
    @(negedge clk);
    chk("bp_busy_after", busy, 0);
    chk("bp_done_count", done_cnt, done_exp);
    tick();

    // Address wrap and ignored valids
    push_op(3, 2, 12'hFE0);
    start_cmd(3, 2, 12'hFE0, 1'b0);
    drive_stream(4, 16, -1, -1);
    wait_done(50);
    tick();
    chk("wrap_idle", busy, 0);

    // Reset in the middle of an operation
    wr_rdy = 1'b0;
    start_cmd(4, 4, 12'h500, 1'b0);
    drive_stream(4, 4, -1, 4);
    @(negedge clk);
    chk("pre_rst_vld", wr_vld, 1);
    dc = done_cnt;
    tick();
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("post_rst_vld", wr_vld, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_no_done", done_cnt, dc);
    tick();
    wr_rdy = 1'b1;
    push_op(2, 2, 12'h610);
    start_cmd(2, 2, 12'h610, 1'b0);
    drive_stream(2, 2, -1, -1);
    wait_done(50);
    tick();

    // Restart guard: command held high across done
    push_op(2, 2, 12'h700);
    start_cmd(2, 2, 12'h700, 1'b1);
    drive_stream(2, 2, -1, -1);
    wait_done(50);
    repeat (6) tick();
    @(negedge clk);
    chk("guard_busy", busy, 0);
    chk("guard_vld", wr_vld, 0);
    chk("guard_done_count", done_cnt, done_exp);
    tick();
    ctrl_vld = 1'b0;
    tick();
    push_op(3, 3, 12'h7A0);
    start_cmd(3, 3, 12'h7A0, 1'b0);
    drive_stream(3, 3, -1, -1);
    wait_done(50);
    tick();

    chk("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mm_wb_buffer.md
Name: mm_wb_buffer

Overview:
- Return-path counterpart of the matrix-multiply operand buffer: collects skewed per-column result bytes from the MXU and de-skews them into 16 row entries of 128 bits.
- Writes each completed row back to the local RAM, one 16-byte line per write, under RAM-side backpressure.
- Sits between the MXU result outputs and the LSU RAM write port. Started by the same ctrl-style command (row_len, col_len, start_addr) as the operand path.

Parameters:
- ROWS, 16, number of row entries, equal to the MXU height.
- COLS, 16, number of byte lanes/columns, equal to the MXU width; data width is 8*COLS.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; one clock, synchronous, active-high (asserted when 1).
- lsu_mm_wb_ctrl_vld  input  1  command level; rising edge while IDLE starts an operation.
- lsu_mm_wb_ctrl_row_len  input  4  rows to collect; 0 encodes 16.
- lsu_mm_wb_ctrl_col_len  input  4  valid columns; 0 encodes 16.
- lsu_mm_wb_ctrl_start_addr  input  12  byte address of row 0; [3:0] must be 0 and is ignored.
- mxu_lsu_wb_vld  input  16  per-column result valid (skewed: row r of column c arrives at cycle r+c).
- mxu_lsu_wb_data  input  128  byte c = column c result.
- lsu_mm_wb_ram_write_vld  output  1  RAM write request.
- lsu_mm_wb_ram_write_rdy  input  1  RAM accepts the write this cycle.
- lsu_mm_wb_ram_write_addr  output  8  line address = start_addr[11:4] + row.
- lsu_mm_wb_ram_write_data  output  128  row entry; bytes >= col_len are driven 0.
- lsu_mm_wb_ram_write_be  output  16  byte enables; bit c = (c < col_len).
- lsu_mm_wb_busy  output  1  operation in progress.
- lsu_mm_wb_done  output  1  one-cycle pulse when the last row write is accepted.

Behaviour:
- Reset: all outputs 0. State IDLE. Per-column row counters, pending mask and entries cleared. The previous ctrl_vld register is cleared.
- FSM IDLE -> COLLECT on ctrl_vld & ~ctrl_vld_ff. On entry, row_len, col_len and start_addr[11:4] are latched and busy=1 from the next cycle. Changes to ctrl inputs after the start are ignored until the FSM returns to IDLE.
- COLLECT, column capture:
  - Each column c < col_len has a 4-bit row counter cnt[c], reset to 0 at start.
  - On mxu_lsu_wb_vld[c] with cnt_done[c]=0: entry[cnt[c]] byte c <= data byte c, and cnt[c] increments.
  - cnt_done[c] sets when the increment reaches row_len.
  - vld bits for c >= col_len, or for columns with cnt_done set, are ignored. vld in IDLE is ignored.
- Row completion:
  - Row r is complete when column col_len-1 writes row r. That column is last in the skew, so at most one row completes per cycle.
  - pending[r] sets on the cycle after that capture.
- Writer:
  - write_vld = |pending, presenting the lowest-index pending row.
  - The addr/data/be outputs are registered from the entry and latched params, and are held stable while vld=1 and rdy=0.
  - On vld & rdy, that pending bit clears and the next pending row is presented the following cycle.
  - Minimum latency: last byte of row r captured in cycle t -> write_vld with row r at t+1, given no older pending rows.
- Address arithmetic: 8-bit modulo add; start_addr[11:4]+r wraps past 0xFF to 0x00.
- COLLECT -> DRAIN when all cnt_done[c] for c < col_len are set. DRAIN -> IDLE when pending==0 after the final accepted write.
  - done pulses in the cycle of that final vld & rdy.
  - busy drops the cycle after done.
- Simultaneous events:
  - A capture and a write acceptance in the same cycle are both performed.
  - A row's pending bit can never be set while that row's entry is being written.
- Backpressure: rdy held low stalls only the writer. Capture continues because all entries are buffered. Rows queue in the pending mask, and the 16-bit mask cannot overflow.
- Reset asserted mid-operation: immediate return to IDLE at the next edge. Pending writes are discarded, and done is not pulsed.
- A new ctrl_vld rising edge while busy is ignored. A new command requires ctrl_vld low then high after IDLE.

Test Plan:
- Directed 4x4:
  - Stimulus: start_addr=0x120, skewed stream, col c row r byte = {r,c}, rdy=1.
  - Required: writes to addr 0x12,0x13,0x14,0x15 in order, row 0 write_vld 4 cycles after first vld; data row r bytes 0..3 = {r,0..3}, bytes 4..15 = 0; be=0x000F; done with last write.
- Full 16x16 (lengths encoded 0):
  - Required: 16 writes, be=0xFFFF, done on 16th accept, busy low next cycle.
- Backpressure, 4x4:
  - Stimulus: rdy=0 until all data captured, then rdy=1.
  - Required: write_vld held with row 0 / addr constant while stalled, then 4 back-to-back writes in row order.
- Wrap and ignore:
  - Stimulus: start_addr=0xFE0, row_len=3, col_len=2; extra vld on columns 2..15 and a 4th row on columns 0..1.
  - Required: addrs 0xFE,0xFF,0x00; ignored bytes never appear; be=0x0003.
- Reset mid-op:
  - Stimulus: rst_n=1 after 2 rows captured with rdy=0.
  - Required: next cycle write_vld=0, busy=0, no done; a following 2x2 command completes normally.
- Restart guard:
  - Stimulus: ctrl_vld held high across done.
  - Required: no second operation; a low-high toggle starts a new one.
